as_gpio_port: RTL
=================

Name: as_gpio_port

Overview:
Memory-mapped GPIO peripheral on the core's data-memory bus. It is the transmitting end of the GPIO/chip-select interface that testbenches monitor.
- A core store to the output register drives the value onto gpio_io.
- cs_o pulses for a programmable number of cycles while that value is stable.
- Pins configured as inputs are synchronised, readable, and optionally raise an edge interrupt.
- Instantiated inside as_top_mem alongside I-Mem/D-Mem.

Parameters:
NR_GPIOS, nr_gpios (as_pack, 8), number of GPIO pins
DATA_WIDTH, 64, bus data width
CS_HOLD, 2, cycles cs_o stays high per output write (>=1)
DIR_RESET, all ones, reset value of the direction register (1 = output)

Ports:
clk_i  in  1  system clock, single clock domain
rst_i  in  1  reset; one clock; reset is synchronous and active-low
we_i  in  1  write request
re_i  in  1  read request
addr_i  in  gpio_addr_width  word address within GPIO space
wdata_i  in  DATA_WIDTH  write data
rdata_o  out  DATA_WIDTH  read data, registered
ready_o  out  1  request accepted this cycle
gpio_io  inout  NR_GPIOS  pins
gpioAddr_o  out  gpio_addr_width  address of last accepted output write
cs_o  out  1  output-valid strobe
irq_o  out  1  level interrupt

Behaviour:
- Register map (word addresses):
  - 0 OUT (rw)
  - 1 DIR (rw)
  - 2 IN (ro)
  - 3 IRQ_STAT (w1c)
  - 4 IRQ_EN (rw)
  - Any other address: writes ignored, reads return 0.
- Widths: only wdata_i[NR_GPIOS-1:0] is used. Reads are zero-extended to DATA_WIDTH.
- Pin drive: gpio_io[i] = DIR[i] ? OUT[i] : 'z.
- Input path: 2-FF synchroniser per pin. IN = sync stage 2 for input pins, OUT[i] for output pins.
- Reads: rdata_o valid the cycle after an accepted re_i and held until the next read. Write and read in the same cycle: write wins, rdata_o unchanged.
- FSM states IDLE and STROBE:
  - IDLE: ready_o=1. A write to OUT updates OUT and gpioAddr_o at the edge, then goes to STROBE with counter=CS_HOLD-1. cs_o is high from the next cycle.
  - STROBE: cs_o=1, ready_o=0 for every request. The core holds the request and it is not accepted. Counter decrements each cycle; at 0, go to IDLE and cs_o falls.
  - Writes to other registers in IDLE complete in one cycle with no strobe.
- gpio_io value is stable for the whole cs_o window. Back-to-back OUT writes therefore yield separate cs_o pulses with at least 1 idle cycle between them.
- Interrupts:
  - A rising edge on synchronised input pin i with IRQ_EN[i]=1 sets IRQ_STAT[i].
  - irq_o = |(IRQ_STAT & IRQ_EN), registered.
  - A w1c write and a new edge on the same bit in the same cycle: the bit stays set.
- Reset (rst_i low at a clock edge): OUT=0, DIR=DIR_RESET, IRQ_STAT=0, IRQ_EN=0, sync FFs=0, state=IDLE, cs_o=0, ready_o=1, rdata_o=0, gpioAddr_o=0, irq_o=0. Reset asserted during STROBE aborts the pulse immediately at that edge.

Optional Feature:
AS_GPIO_IRQ_EN
- Defined: IRQ_STAT, IRQ_EN, edge detectors and irq_o logic are present as described.
- Undefined: those registers are not built, addresses 3/4 behave as unmapped, and irq_o is tied 0.

Decomposition:
- as_pack additions:
  - nr_gpios, gpio_addr_width
  - register offset constants GPIO_OUT_ADDR=0, GPIO_DIR_ADDR=1, GPIO_IN_ADDR=2, GPIO_IRQSTAT_ADDR=3, GPIO_IRQEN_ADDR=4
  - enum gpio_state_t {GPIO_IDLE, GPIO_STROBE}
- One sub-module: as_gpio_sync, a parameterised-width 2-FF synchroniser with registered rising-edge output, reused for any future async inputs.

Test Plan:
- Reset, then write 137 to addr 0 → next cycle cs_o=1 for exactly 2 cycles, gpio_io=0x89 throughout, gpioAddr_o=0, ready_o=0 during strobe.
- Write 119 then immediately 254 to addr 0 → ready_o=0 stalls the second write. Two distinct cs_o pulses with 0x77 then 0xFE, at least 1 idle cycle between them.
- Write DIR=0x0F, OUT=0xFF, drive pins [7:4]=0xA externally; read addr 2 at least 3 cycles later → rdata_o=0xAF next cycle, upper bits 0.
- With AS_GPIO_IRQ_EN: IRQ_EN=0x10, pin 4 rises → irq_o=1 within 3 cycles. Write 0x10 to addr 3 → irq_o=0 next cycle. Same-cycle edge plus w1c → stays 1.
- Assert rst_i low in the middle of a CS_HOLD=4 strobe → cs_o=0 and gpio_io=0 after that edge, ready_o=1.
- Write and read addr 5 → no state change, rdata_o=0.

Source files
------------

// File: rtl/as_gpio_port_pkg.sv
// Shared constants and types for the memory-mapped GPIO port.
package as_gpio_port_pkg;

  localparam int unsigned nr_gpios        = 8;
  localparam int unsigned gpio_addr_width = 3;

  localparam logic [gpio_addr_width-1:0] GPIO_OUT_ADDR     = 3'd0;
  localparam logic [gpio_addr_width-1:0] GPIO_DIR_ADDR     = 3'd1;
  localparam logic [gpio_addr_width-1:0] GPIO_IN_ADDR      = 3'd2;
  localparam logic [gpio_addr_width-1:0] GPIO_IRQSTAT_ADDR = 3'd3;
  localparam logic [gpio_addr_width-1:0] GPIO_IRQEN_ADDR   = 3'd4;

  typedef enum logic {
    GPIO_IDLE   = 1'b0,
    GPIO_STROBE = 1'b1
  } gpio_state_t;

endpackage

// File: rtl/as_gpio_port_sync.sv
// Parameterised-width 2-FF synchroniser with a registered rising-edge flag.
module as_gpio_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_rise;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_rise <= '0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_rise <= r_s1 & ~r_s2;
    end
  end

  assign o_q    = r_s2;
  assign o_rise = r_rise;

endmodule

// File: rtl/as_gpio_port.sv
// Memory-mapped GPIO port with a cs_o strobe per OUT write.
// Define AS_GPIO_IRQ_EN to build the edge-interrupt registers (IRQ_STAT/IRQ_EN) and irq_o.
module as_gpio_port
  import as_gpio_port_pkg::*;
#(
  parameter int unsigned         NR_GPIOS   = nr_gpios,
  parameter int unsigned         DATA_WIDTH = 64,
  parameter int unsigned         CS_HOLD    = 2,
  parameter logic [NR_GPIOS-1:0] DIR_RESET  = '1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we_i,
  input  logic                       re_i,
  input  logic [gpio_addr_width-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       ready_o,
  inout  wire  [NR_GPIOS-1:0]        gpio_io,
  output logic [gpio_addr_width-1:0] gpioAddr_o,
  output logic                       cs_o,
  output logic                       irq_o
);

  localparam int unsigned CNT_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

  gpio_state_t         r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [NR_GPIOS-1:0] r_out;
  logic [NR_GPIOS-1:0] r_dir;
  logic [NR_GPIOS-1:0] w_sync;
  logic [NR_GPIOS-1:0] w_rise;
  logic [NR_GPIOS-1:0] w_in;
  logic [NR_GPIOS-1:0] w_wdata;
  logic [NR_GPIOS-1:0] w_rd_val;
  logic                w_wr;
  logic                w_unused_wdata;

  assign w_wdata        = wdata_i[NR_GPIOS-1:0];
  assign w_unused_wdata = ^wdata_i[DATA_WIDTH-1:NR_GPIOS];
  assign w_wr           = (r_state == GPIO_IDLE) && we_i;

  for (genvar i = 0; i < NR_GPIOS; i++) begin : g_pin
    assign gpio_io[i] = r_dir[i] ? r_out[i] : 1'bz;
  end

  as_gpio_sync #(.WIDTH(NR_GPIOS)) u_sync (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_d     (gpio_io),
    .o_q     (w_sync),
    .o_rise  (w_rise)
  );

  // Output pins read back their own drive value rather than the synchronised pin.
  assign w_in = (r_dir & r_out) | (~r_dir & w_sync);

`ifdef AS_GPIO_IRQ_EN
  logic [NR_GPIOS-1:0] r_irq_stat;
  logic [NR_GPIOS-1:0] r_irq_en;
  logic [NR_GPIOS-1:0] w_stat_nxt;
  logic [NR_GPIOS-1:0] w_en_nxt;
  logic [NR_GPIOS-1:0] w_clr;
  logic [NR_GPIOS-1:0] w_edge;

  // A fresh edge beats a same-cycle w1c on the same bit.
  always_comb begin
    w_en_nxt = r_irq_en;
    w_clr    = '0;
    if (w_wr && (addr_i == GPIO_IRQEN_ADDR))   w_en_nxt = w_wdata;
    if (w_wr && (addr_i == GPIO_IRQSTAT_ADDR)) w_clr    = w_wdata;
    w_edge     = w_rise & ~r_dir & r_irq_en;
    w_stat_nxt = (r_irq_stat & ~w_clr) | w_edge;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_irq_stat <= '0;
      r_irq_en   <= '0;
      irq_o      <= 1'b0;
    end else begin
      r_irq_stat <= w_stat_nxt;
      r_irq_en   <= w_en_nxt;
      irq_o      <= |(w_stat_nxt & w_en_nxt);
    end
  end
`else
  logic w_unused_rise;
  assign w_unused_rise = ^w_rise;
  assign irq_o         = 1'b0;
`endif

  always_comb begin
    w_rd_val = '0;
    case (addr_i)
      GPIO_OUT_ADDR:     w_rd_val = r_out;
      GPIO_DIR_ADDR:     w_rd_val = r_dir;
      GPIO_IN_ADDR:      w_rd_val = w_in;
`ifdef AS_GPIO_IRQ_EN
      GPIO_IRQSTAT_ADDR: w_rd_val = r_irq_stat;
      GPIO_IRQEN_ADDR:   w_rd_val = r_irq_en;
`endif
      default:           w_rd_val = '0;
    endcase
  end

  // Bus/strobe FSM: OUT writes hold the bus off for CS_HOLD cycles of cs_o.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= GPIO_IDLE;
      r_cnt      <= '0;
      r_out      <= '0;
      r_dir      <= DIR_RESET;
      cs_o       <= 1'b0;
      ready_o    <= 1'b1;
      rdata_o    <= '0;
      gpioAddr_o <= '0;
    end else begin
      case (r_state)
        GPIO_IDLE: begin
          if (we_i) begin
            case (addr_i)
              GPIO_OUT_ADDR: begin
                r_out      <= w_wdata;
                gpioAddr_o <= addr_i;
                r_cnt      <= CNT_W'(CS_HOLD - 1);
                r_state    <= GPIO_STROBE;
                cs_o       <= 1'b1;
                ready_o    <= 1'b0;
              end
              GPIO_DIR_ADDR: r_dir <= w_wdata;
              default: ;
            endcase
          end else if (re_i) begin
            rdata_o <= DATA_WIDTH'(w_rd_val);
          end
        end
        GPIO_STROBE: begin
          if (r_cnt == '0) begin
            r_state <= GPIO_IDLE;
            cs_o    <= 1'b0;
            ready_o <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= GPIO_IDLE;
      endcase
    end
  end

endmodule
